// File: rtl/pll_reconfig_ctrl_if.sv
// Divider-change request channel into pll_reconfig_ctrl.
// master: cfg_req + cfg_ratio* out, cfg_ack/cfg_err in; slave: reverse.
interface pll_reconfig_ctrl_if;
    logic       cfg_req;
    logic [9:0] cfg_ratioi;
    logic [9:0] cfg_ratiof;
    logic [9:0] cfg_ratio0;
    logic [9:0] cfg_ratio1;
    logic       cfg_ack;
    logic       cfg_err;

    modport master (
        output cfg_req, cfg_ratioi, cfg_ratiof, cfg_ratio0, cfg_ratio1,
        input  cfg_ack, cfg_err
    );
    modport slave (
        input  cfg_req, cfg_ratioi, cfg_ratiof, cfg_ratio0, cfg_ratio1,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer with runtime divider reconfiguration.
// Ports: sys_clk/sys_rst_n, raw pll_lock, cfg slave, PLL controls, status.
module pll_reconfig_ctrl #(
    parameter int unsigned DEF_RATIOI   = 9,
    parameter int unsigned DEF_RATIOF   = 212,
    parameter int unsigned DEF_RATIO0   = 23,
    parameter int unsigned DEF_RATIO1   = 118,
    parameter int unsigned RST_CYCLES   = 64,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 500000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                pll_lock,
    pll_reconfig_ctrl_if.slave  cfg,
    output logic                pll_rst,
    output logic [9:0]          pll_ratioi,
    output logic [9:0]          pll_ratiof,
    output logic [9:0]          pll_ratio0,
    output logic [9:0]          pll_ratio1,
    output logic [9:0]          pll_duty0,
    output logic [9:0]          pll_duty1,
    output logic                clk_rdy,
    output logic                pll_fail,
    output logic [7:0]          lock_loss_cnt
);
    localparam int CW = $clog2(LOCK_TIMEOUT + RST_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [9:0]    DI       = 10'(DEF_RATIOI);
    localparam logic [9:0]    DF       = 10'(DEF_RATIOF);
    localparam logic [9:0]    D0       = 10'(DEF_RATIO0);
    localparam logic [9:0]    D1       = 10'(DEF_RATIO1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB      = SW'(LOCK_STABLE);
    localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        RST_ASSERT, WAIT_LOCK, READY, FAIL
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [SW-1:0] scnt, scnt_d;
    logic [RW-1:0] retry, retry_d;
    logic [1:0]    sync;
    logic          lock_s;
    logic          rdy_d, fail_d, ack_d, err_d;
    logic          loss_inc, load_pend, load_out;
    logic          sample, ratios_ok;
    logic [9:0]    pend_i, pend_f, pend_0, pend_1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync <= 2'b00;
        else            sync <= {sync[0], pll_lock};
    end
    assign lock_s = sync[1];

    assign ratios_ok = (|cfg.cfg_ratioi) && (|cfg.cfg_ratiof)
                    && (|cfg.cfg_ratio0) && (|cfg.cfg_ratio1);
    // Lock loss in READY outranks a same-cycle request.
    assign sample = (state == READY && lock_s) || (state == FAIL);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        scnt_d    = scnt;
        retry_d   = retry;
        rdy_d     = clk_rdy;
        fail_d    = pll_fail;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        loss_inc  = 1'b0;
        load_pend = 1'b0;
        load_out  = 1'b0;
        unique case (state)
            RST_ASSERT: begin
                // Ratios move only while the PLL is held in reset.
                load_out = (cnt == '0);
                cnt_d    = cnt + 1'b1;
                if (cnt == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    scnt_d  = '0;
                end
            end
            WAIT_LOCK: begin
                cnt_d  = cnt + 1'b1;
                scnt_d = lock_s ? scnt + 1'b1 : '0;
                if (scnt == STB) begin
                    state_d = READY;
                    rdy_d   = 1'b1;
                    retry_d = '0;
                    cnt_d   = '0;
                    scnt_d  = '0;
                end else if (cnt == TO_LAST) begin
                    retry_d = retry + 1'b1;
                    cnt_d   = '0;
                    if (retry_d == RMAX) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = RST_ASSERT;
                    end
                end
            end
            READY: begin
                if (!lock_s) begin
                    state_d  = RST_ASSERT;
                    rdy_d    = 1'b0;
                    loss_inc = 1'b1;
                    cnt_d    = '0;
                end
            end
            FAIL: begin
            end
            default: state_d = RST_ASSERT;
        endcase
        if (sample && cfg.cfg_req) begin
            if (!ratios_ok) begin
                err_d = 1'b1;
            end else begin
                ack_d     = 1'b1;
                load_pend = 1'b1;
                rdy_d     = 1'b0;
                fail_d    = 1'b0;
                retry_d   = '0;
                cnt_d     = '0;
                state_d   = RST_ASSERT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= RST_ASSERT;
            cnt           <= '0;
            scnt          <= '0;
            retry         <= '0;
            pll_rst       <= 1'b1;
            clk_rdy       <= 1'b0;
            pll_fail      <= 1'b0;
            cfg.cfg_ack   <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            lock_loss_cnt <= '0;
            pend_i        <= DI;
            pend_f        <= DF;
            pend_0        <= D0;
            pend_1        <= D1;
            pll_ratioi    <= DI;
            pll_ratiof    <= DF;
            pll_ratio0    <= D0;
            pll_ratio1    <= D1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            scnt        <= scnt_d;
            retry       <= retry_d;
            pll_rst     <= (state_d == RST_ASSERT) || (state_d == FAIL);
            clk_rdy     <= rdy_d;
            pll_fail    <= fail_d;
            cfg.cfg_ack <= ack_d;
            cfg.cfg_err <= err_d;
            if (loss_inc && lock_loss_cnt != 8'hff)
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            if (load_pend) begin
                pend_i <= cfg.cfg_ratioi;
                pend_f <= cfg.cfg_ratiof;
                pend_0 <= cfg.cfg_ratio0;
                pend_1 <= cfg.cfg_ratio1;
            end
            if (load_out) begin
                pll_ratioi <= pend_i;
                pll_ratiof <= pend_f;
                pll_ratio0 <= pend_0;
                pll_ratio1 <= pend_1;
            end
        end
    end

    // 50% duty: high time equals the divider value in the PLL encoding.
    assign pll_duty0 = pll_ratio0;
    assign pll_duty1 = pll_ratio1;
endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer for the dynamic-ratio PLL instance clocked from the 50 MHz board reference.
- Performs the power-up reset/lock sequence and filters lock stability.
- Accepts runtime divider-change requests, recovers on lock loss with bounded retries, and drives `clk_rdy` to downstream domain reset generators.
- Runs on the free-running reference clock, never on a PLL output.

Parameters:
- DEF_RATIOI, 9, power-up input divider
- DEF_RATIOF, 212, power-up feedback divider
- DEF_RATIO0, 23, power-up clkout0 divider
- DEF_RATIO1, 118, power-up clkout1 divider
- RST_CYCLES, 64, `pll_rst` high time in `sys_clk` cycles (min 4)
- LOCK_STABLE, 1024, consecutive synced-lock cycles required before ready
- LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK per attempt (10 ms)
- MAX_RETRY, 3, failed attempts before FAIL

Ports:
- sys_clk  in  1  50 MHz reference clock, also PLL clkin1
- sys_rst_n  in  1  async active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous
- cfg_req  in  1  reconfiguration request, level, held until ack
- cfg_ratioi  in  10  requested input divider
- cfg_ratiof  in  10  requested feedback divider
- cfg_ratio0  in  10  requested clkout0 divider
- cfg_ratio1  in  10  requested clkout1 divider
- cfg_ack  out  1  one-cycle pulse: request accepted
- cfg_err  out  1  one-cycle pulse: request rejected (zero divider)
- pll_rst  out  1  PLL reset
- pll_ratioi / pll_ratiof / pll_ratio0 / pll_ratio1  out  10 each  divider values to PLL
- pll_duty0 / pll_duty1  out  10 each  equal to pll_ratio0 / pll_ratio1 (50% duty encoding)
- clk_rdy  out  1  PLL locked and stable
- pll_fail  out  1  sticky: retries exhausted
- lock_loss_cnt  out  8  saturating count of lock losses seen in READY

Behaviour:
- Interface: one clock (`sys_clk`); reset `sys_rst_n` is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state RST_ASSERT, counters 0.
  - `pll_rst`=1, ratios/duties=DEF_*.
  - `clk_rdy`=0, `pll_fail`=0, `cfg_ack`=0, `cfg_err`=0, `lock_loss_cnt`=0.
- `pll_lock` passes through a 2-flop synchronizer (reset 0); `lock_s` denotes the synced value.
- RST_ASSERT:
  - `pll_rst`=1; counter runs 0..RST_CYCLES-1, then next state WAIT_LOCK.
  - `pll_rst` is high for exactly RST_CYCLES cycles per entry.
  - Pending ratio registers are copied to the `pll_ratio*`/`pll_duty*` outputs on cycle 1 of RST_ASSERT, so ratios never change while `pll_rst`=0.
- WAIT_LOCK:
  - `pll_rst`=0; timeout counter increments every cycle.
  - Stable counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - Stable counter reaches LOCK_STABLE: go to READY, `clk_rdy`=1 next cycle, retry counter cleared.
  - Timeout reaches LOCK_TIMEOUT first: increment retry counter; if it now equals MAX_RETRY go to FAIL, otherwise go to RST_ASSERT.
  - If stable and timeout complete on the same cycle, stable wins.
- READY:
  - `lock_s`=0: `clk_rdy`=0 on the next edge, `lock_loss_cnt` +1 (saturates at 255), go to RST_ASSERT with unchanged ratios.
  - Lock loss takes priority over a simultaneous `cfg_req`; that request stays pending until READY or FAIL is re-entered.
- FAIL: `pll_rst`=1, `pll_fail`=1 (sticky until `sys_rst_n` or an accepted `cfg_req`), `clk_rdy`=0.
- cfg handshake:
  - Sampled only in READY or FAIL; ignored in all other states (no ack, no err).
  - If any `cfg_ratio*`==0: `cfg_err` pulses one cycle; state and ratios unchanged.
  - Otherwise: latch all four values into the pending ratio registers and pulse `cfg_ack` one cycle. Same edge: `clk_rdy`=0, `pll_fail`=0, retry counter cleared, go to RST_ASSERT.
  - The requester must drop `cfg_req` after the ack. A still-high `cfg_req` is re-sampled only after READY or FAIL is reached again.
- `sys_rst_n` assertion mid-sequence returns every output immediately to its reset value, including restoring DEF_* ratios.

Test Plan (bench parameters: RST_CYCLES=8, LOCK_STABLE=16, LOCK_TIMEOUT=200, MAX_RETRY=3):
- Power-up:
  - Stimulus: release reset; `pll_lock` rises 20 cycles later and stays high.
  - Required: `pll_rst` high exactly 8 cycles; `clk_rdy`=1 exactly 2+16+1 cycles after `pll_lock` rises; ratios read 9/212/23/118.
- Lock glitch in WAIT_LOCK:
  - Stimulus: `pll_lock` high 10 cycles, low 1 cycle, then high.
  - Required: stable counter restarts; `clk_rdy` is delayed by the full 16 cycles counted from the re-rise.
- Reconfiguration:
  - Stimulus: in READY, `cfg_req` with 5/100/20/40.
  - Required: one `cfg_ack` pulse; `clk_rdy`=0; `pll_rst` high 8 cycles; ratios show 5/100/20/40 while `pll_rst`=1; duties equal ratios; relock returns `clk_rdy`=1.
- Rejection and ignore:
  - Stimulus: in READY, `cfg_req` with `cfg_ratiof`=0; separately, `cfg_req` during WAIT_LOCK.
  - Required: `cfg_err` pulses once with no state change; no ack or err while in WAIT_LOCK.
- Timeout/FAIL:
  - Stimulus: `pll_lock` held 0.
  - Required: three attempts of 8 + 200 cycles each; then `pll_fail`=1 and `pll_rst`=1 held; a valid `cfg_req` clears `pll_fail` and restarts the sequence.
- Lock loss and reset:
  - Stimulus: drop `pll_lock` in READY 300 times, relocking each time; then assert `sys_rst_n` during WAIT_LOCK.
  - Required: `lock_loss_cnt` reads 255 (saturated); reset instantly restores `pll_rst`=1 and DEF_* ratios.
